// File: rtl/writeback.sv
// Final MIPS pipeline stage: picks the result (ALU, load data or link address),
// resolves the destination register, drives the register-file write port and counts retirements.
module writeback #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_writeback,
  output logic                 ready_writeback,
  input  logic [31:0]          insn_in,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic [WIDTH-1:0]     dVal_regfile,
  output logic [REG_WIDTH-1:0] rdIn_regfile,
  output logic                 we_regfile,
  output logic [31:0]          retired_count
);

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  typedef enum logic [1:0] {LD_W, LD_B, LD_BU} ld_kind_t;

  state_t                 state_q, state_d;
  ld_kind_t               ld_kind_q, ld_kind_d;
  logic [REG_WIDTH-1:0]   ld_dest_q, ld_dest_d;
  logic [1:0]             ld_off_q, ld_off_d;
  logic                   we_q, we_d;
  logic [WIDTH-1:0]       dval_q, dval_d;
  logic [REG_WIDTH-1:0]   rd_q, rd_d;
  logic [31:0]            count_q, count_d;

  logic [5:0]             opcode, funct;
  logic [REG_WIDTH-1:0]   rt_field, rd_field;
  logic [WIDTH-1:0]       link_addr;
  logic                   dec_we, dec_load;
  ld_kind_t               dec_kind;
  logic [REG_WIDTH-1:0]   dec_dest;
  logic [WIDTH-1:0]       dec_data;
  logic [WIDTH-1:0]       load_data;
  logic                   accept;
  logic                   unused_bits;

  // Big-endian byte lane: offset 0 is the most significant byte.
  function automatic logic [7:0] select_byte(input logic [WIDTH-1:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] extend_byte(input logic [7:0] b, input logic sign_ext);
    return sign_ext ? {{(WIDTH-8){b[7]}}, b} : {{(WIDTH-8){1'b0}}, b};
  endfunction

  assign opcode      = insn_in[31:26];
  assign funct       = insn_in[5:0];
  assign rt_field    = insn_in[20:16];
  assign rd_field    = insn_in[15:11];
  assign link_addr   = pc_in + WIDTH'(8);
  assign unused_bits = ^{insn_in[25:21], insn_in[10:6]};

  assign ready_writeback = (state_q == IDLE);
  assign accept          = enable_writeback && ready_writeback;

  always_comb begin
    dec_we   = 1'b0;
    dec_load = 1'b0;
    dec_kind = LD_W;
    dec_dest = rt_field;
    dec_data = alu_result;
    case (opcode)
      OP_SPECIAL: begin
        dec_dest = rd_field;
        case (funct)
          FN_JALR: begin
            dec_we   = 1'b1;
            dec_data = link_addr;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_JR: dec_we = 1'b0;
          default: dec_we = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        dec_dest = rd_field;
        dec_we   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LUI: dec_we = 1'b1;
      OP_JAL: begin
        dec_we   = 1'b1;
        dec_dest = REG_WIDTH'(31);
        dec_data = link_addr;
      end
      OP_LW: dec_load = 1'b1;
      OP_LB: begin
        dec_load = 1'b1;
        dec_kind = LD_B;
      end
      OP_LBU: begin
        dec_load = 1'b1;
        dec_kind = LD_BU;
      end
      default: dec_we = 1'b0;
    endcase
  end

  always_comb begin
    case (ld_kind_q)
      LD_B:    load_data = extend_byte(select_byte(mem_rdata, ld_off_q), 1'b1);
      LD_BU:   load_data = extend_byte(select_byte(mem_rdata, ld_off_q), 1'b0);
      default: load_data = mem_rdata;
    endcase
  end

  // Write data/address only move on an actual write; otherwise they hold.
  always_comb begin
    state_d   = state_q;
    ld_kind_d = ld_kind_q;
    ld_dest_d = ld_dest_q;
    ld_off_d  = ld_off_q;
    we_d      = 1'b0;
    dval_d    = dval_q;
    rd_d      = rd_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_load) begin
            state_d   = WAIT_LOAD;
            ld_kind_d = dec_kind;
            ld_dest_d = rt_field;
            ld_off_d  = alu_result[1:0];
          end else begin
            count_d = count_q + 32'd1;
            if (dec_we && (dec_dest != '0)) begin
              we_d   = 1'b1;
              dval_d = dec_data;
              rd_d   = dec_dest;
            end
          end
        end
      end
      WAIT_LOAD: begin
        state_d = IDLE;
        count_d = count_q + 32'd1;
        if (ld_dest_q != '0) begin
          we_d   = 1'b1;
          dval_d = load_data;
          rd_d   = ld_dest_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ld_kind_q <= LD_W;
      ld_dest_q <= '0;
      ld_off_q  <= '0;
      we_q      <= 1'b0;
      dval_q    <= '0;
      rd_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ld_kind_q <= ld_kind_d;
      ld_dest_q <= ld_dest_d;
      ld_off_q  <= ld_off_d;
      we_q      <= we_d;
      dval_q    <= dval_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end

  assign we_regfile    = we_q;
  assign dVal_regfile  = dval_q;
  assign rdIn_regfile  = rd_q;
  assign retired_count = count_q;

endmodule
